// File: rtl/cache_pkg.sv
// Shared cache/memory-side definitions: field widths and the responder state encoding.
package cache_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_W    = 18;
  localparam int unsigned INDEX_W  = 8;
  localparam int unsigned OFFSET_W = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    COOL  = 3'd4
  } resp_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Cache <-> backing-memory bus: fill request/response and eviction writeback.
interface mem_responder_if #(
  parameter int unsigned ADDR_W = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W = cache_pkg::DATA_W
) ();

  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              i_evict;
  logic [ADDR_W-1:0] i_evict_addr;
  logic [DATA_W-1:0] i_evict_data;
  logic [DATA_W-1:0] o_memory_line;
  logic              o_memory_response;
  logic              o_evict_ready;
  logic              o_overflow;
  logic              o_busy;

  // Cache side drives requests and writebacks
  modport master (
    output i_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data,
    input  o_memory_line, o_memory_response, o_evict_ready, o_overflow, o_busy
  );

  // Memory side answers them
  modport slave (
    input  i_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data,
    output o_memory_line, o_memory_response, o_evict_ready, o_overflow, o_busy
  );

endinterface

// File: rtl/mem_responder_wb_fifo.sv
// Writeback buffer: circular FIFO with occupancy count and full/empty flags.
module wb_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_c,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full_c,
  output logic                         empty_c
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             push_ok_c;
  logic             pop_ok_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full_c    = (count == CNT_W'(DEPTH));
  assign empty_c   = (count == '0);
  assign push_ok_c = push && !full_c;
  assign pop_ok_c  = pop && !empty_c;
  assign head_c    = mem_q[rd_ptr_q];

  // Entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok_c, pop_ok_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Backing memory for sa_cache: serves one fill at a time after a fixed latency
// and commits buffered eviction writebacks to a word-addressed array.
module mem_responder #(
  parameter int unsigned ADDR_W     = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W     = cache_pkg::DATA_W,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned WB_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  import cache_pkg::*;

  localparam int unsigned WORDS   = 1 << DEPTH_LOG2;
  localparam int unsigned ENTRY_W = DEPTH_LOG2 + DATA_W;
  localparam int unsigned CNT_W   = $clog2(WB_DEPTH + 1);
  localparam int unsigned LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  resp_state_e            state_q;
  resp_state_e            state_nxt;
  logic [LAT_W-1:0]       lat_q;
  logic [LAT_W-1:0]       lat_nxt;
  logic                   capture_c;
  logic [DEPTH_LOG2-1:0]  miss_idx_q;

  logic [DATA_W-1:0]      line_q;
  logic                   resp_q;
  logic                   busy_q;
  logic                   overflow_q;

  logic                   ready_c;
  logic                   enq_c;
  logic                   deq_c;
  logic [ENTRY_W-1:0]     head_c;
  logic [CNT_W-1:0]       wb_count;
  logic [CNT_W-1:0]       cnt_after_c;
  logic                   wb_full_c;
  logic                   wb_empty_c;

  logic [DATA_W-1:0]      mem_q [WORDS];

  // Upper address bits alias and byte-offset bits are don't-care
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_miss_addr[ADDR_W-1:DEPTH_LOG2+2], bus.i_miss_addr[1:0],
                              bus.i_evict_addr[ADDR_W-1:DEPTH_LOG2+2], bus.i_evict_addr[1:0]};

  // Ready ignores a same-cycle dequeue; held low during reset
  assign ready_c = !rst && !wb_full_c;
  assign enq_c   = bus.i_evict && ready_c;
  // Commit oldest entry in IDLE/DRAIN; the IDLE cycle that accepts a miss does not commit
  assign deq_c   = !rst && !wb_empty_c &&
                   ((state_q == DRAIN) || ((state_q == IDLE) && !bus.i_miss));
  assign cnt_after_c = wb_count + CNT_W'(enq_c) - CNT_W'(deq_c);

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq_c),
    .push_data ({bus.i_evict_addr[DEPTH_LOG2+1:2], bus.i_evict_data}),
    .pop       (deq_c),
    .head_c    (head_c),
    .count     (wb_count),
    .full_c    (wb_full_c),
    .empty_c   (wb_empty_c)
  );

  // Storage array commit from the writeback buffer (contents survive reset)
  always_ff @(posedge clk) begin
    if (deq_c) mem_q[head_c[ENTRY_W-1:DATA_W]] <= head_c[DATA_W-1:0];
  end

  // Next-state, latency counter and address capture
  always_comb begin
    state_nxt = state_q;
    lat_nxt   = lat_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_miss) begin
          capture_c = 1'b1;
          if (!wb_empty_c || enq_c) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = WAIT;
            lat_nxt   = LAT_W'(LATENCY - 1);
          end
        end
      end
      DRAIN: begin
        if (cnt_after_c == '0) begin
          state_nxt = WAIT;
          lat_nxt   = LAT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (lat_q == '0) state_nxt = RESP;
        else             lat_nxt   = lat_q - LAT_W'(1);
      end
      RESP:    state_nxt = COOL;
      COOL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and captured fill index
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q <= state_nxt;
      lat_q   <= lat_nxt;
      if (capture_c) miss_idx_q <= bus.i_miss_addr[DEPTH_LOG2+1:2];
    end
  end

  // Registered outputs: array read on entry to RESP, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q     <= '0;
      resp_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      resp_q <= (state_nxt == RESP);
      busy_q <= (state_nxt != IDLE);
      if (state_nxt == RESP)           line_q     <= mem_q[miss_idx_q];
      if (bus.i_evict && !ready_c)     overflow_q <= 1'b1;
    end
  end

  assign bus.o_memory_line     = line_q;
  assign bus.o_memory_response = resp_q;
  assign bus.o_evict_ready     = ready_c;
  assign bus.o_overflow        = overflow_q;
  assign bus.o_busy            = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: fill table plus overflow, held-miss and reset sequences.
module tb_mem_responder;

  localparam int L = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_responder #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .DEPTH_LOG2 (10),
    .LATENCY    (L),
    .WB_DEPTH   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        evict;
    logic        same_edge;
    logic [31:0] ev_addr;
    logic [31:0] ev_data;
    logic [31:0] miss_addr;
    logic [31:0] exp_line;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Single eviction in IDLE, then give it time to commit
  task automatic idle_evict(input logic [31:0] a, input logic [31:0] d);
    bus.i_evict      = 1'b1;
    bus.i_evict_addr = a;
    bus.i_evict_data = d;
    @(negedge clk);
    bus.i_evict = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Raise a miss (optionally with a same-edge eviction) and check latency, line and pulse shape
  task automatic do_fill(input string name, input logic [31:0] addr, input int exp_lat,
                         input logic [31:0] exp_line, input logic ev, input logic [31:0] ea,
                         input logic [31:0] ed, input logic hold);
    int n;
    bus.i_miss      = 1'b1;
    bus.i_miss_addr = addr;
    if (ev) begin
      bus.i_evict      = 1'b1;
      bus.i_evict_addr = ea;
      bus.i_evict_data = ed;
    end
    @(negedge clk);
    bus.i_evict = 1'b0;
    n = 0;
    while (!bus.o_memory_response && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    chk({name, "_line"}, bus.o_memory_line, exp_line);
    if (!hold) bus.i_miss = 1'b0;
    @(negedge clk);
    chk({name, "_pulse_width"}, 32'(bus.o_memory_response), 32'd0);
    chk({name, "_busy_cool"}, 32'(bus.o_busy), 32'd1);
    bus.i_miss = 1'b0;
    @(negedge clk);
    chk({name, "_busy_idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] ov_addr [4];
    logic [31:0] ov_data [4];
    int          resp_cnt;
    logic [31:0] resp_line;
    logic        extra;

    checks = 0;
    errors = 0;

    vecs[0] = '{evict: 1'b1, same_edge: 1'b0, ev_addr: 32'h0000_0040, ev_data: 32'hDEAD_BEEF,
                miss_addr: 32'h0000_0040, exp_line: 32'hDEAD_BEEF, exp_lat: L};
    vecs[1] = '{evict: 1'b1, same_edge: 1'b1, ev_addr: 32'h0000_0080, ev_data: 32'h1234_5678,
                miss_addr: 32'h0000_0080, exp_line: 32'h1234_5678, exp_lat: L + 1};
    vecs[2] = '{evict: 1'b0, same_edge: 1'b0, ev_addr: 32'h0,         ev_data: 32'h0,
                miss_addr: 32'h0000_0040, exp_line: 32'hDEAD_BEEF, exp_lat: L};
    vecs[3] = '{evict: 1'b1, same_edge: 1'b0, ev_addr: 32'h0000_1040, ev_data: 32'hCAFE_F00D,
                miss_addr: 32'h0000_0043, exp_line: 32'hCAFE_F00D, exp_lat: L};
    vecs[4] = '{evict: 1'b1, same_edge: 1'b1, ev_addr: 32'h0000_00C0, ev_data: 32'hA5A5_A5A5,
                miss_addr: 32'h0000_0080, exp_line: 32'h1234_5678, exp_lat: L + 1};

    ov_addr = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
    ov_data = '{32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004};

    bus.i_miss       = 1'b0;
    bus.i_miss_addr  = '0;
    bus.i_evict      = 1'b0;
    bus.i_evict_addr = '0;
    bus.i_evict_data = '0;
    rst              = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_line", bus.o_memory_line, 32'h0);
    chk("rst_resp", 32'(bus.o_memory_response), 32'd0);
    chk("rst_ready", 32'(bus.o_evict_ready), 32'd0);
    chk("rst_overflow", 32'(bus.o_overflow), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.o_evict_ready), 32'd1);
    chk("post_rst_busy", 32'(bus.o_busy), 32'd0);

    // Fill table
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].evict && !vecs[i].same_edge) idle_evict(vecs[i].ev_addr, vecs[i].ev_data);
      do_fill($sformatf("vec%0d", i), vecs[i].miss_addr, vecs[i].exp_lat, vecs[i].exp_line,
              vecs[i].same_edge, vecs[i].ev_addr, vecs[i].ev_data, 1'b0);
    end

    // Overflow: five evictions while a fill is waiting
    bus.i_miss      = 1'b1;
    bus.i_miss_addr = 32'h0000_0080;
    @(negedge clk);
    resp_cnt  = 0;
    resp_line = '0;
    for (int i = 0; i < 5; i++) begin
      bus.i_evict      = 1'b1;
      bus.i_evict_addr = (i < 4) ? ov_addr[i] : 32'h0000_0100;
      bus.i_evict_data = (i < 4) ? ov_data[i] : 32'hBAD0_BAD0;
      @(negedge clk);
      if (bus.o_memory_response) begin
        resp_cnt++;
        resp_line = bus.o_memory_line;
      end
      if (i == 2) chk("ov_ready_after_3", 32'(bus.o_evict_ready), 32'd1);
      if (i == 3) chk("ov_ready_after_4", 32'(bus.o_evict_ready), 32'd0);
      if (i == 4) chk("ov_overflow_set", 32'(bus.o_overflow), 32'd1);
    end
    bus.i_evict = 1'b0;
    bus.i_miss  = 1'b0;
    chk("ov_resp_count", 32'(resp_cnt), 32'd1);
    chk("ov_resp_line", resp_line, 32'h1234_5678);
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("ov_overflow_sticky", 32'(bus.o_overflow), 32'd1);
    chk("ov_ready_drained", 32'(bus.o_evict_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_fill($sformatf("ov_read%0d", i), ov_addr[i], L, ov_data[i], 1'b0, 32'h0, 32'h0, 1'b0);
    end
    chk("ov_overflow_still", 32'(bus.o_overflow), 32'd1);

    // Miss held one cycle past the pulse must not start a second fill
    do_fill("hold", 32'h0000_0104, L, 32'hAAAA_0002, 1'b0, 32'h0, 32'h0, 1'b1);
    extra = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_memory_response || bus.o_busy) extra = 1'b1;
    end
    chk("hold_no_second_fill", 32'(extra), 32'd0);

    // Reset during WAIT with two entries buffered
    bus.i_miss      = 1'b1;
    bus.i_miss_addr = 32'h0000_0300;
    @(negedge clk);
    bus.i_miss       = 1'b0;
    bus.i_evict      = 1'b1;
    bus.i_evict_addr = 32'h0000_0040;
    bus.i_evict_data = 32'h1111_1111;
    @(negedge clk);
    bus.i_evict_data = 32'h2222_2222;
    @(negedge clk);
    bus.i_evict = 1'b0;
    rst         = 1'b1;
    extra       = 1'b0;
    @(negedge clk);
    if (bus.o_memory_response) extra = 1'b1;
    chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    if (bus.o_memory_response) extra = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    if (bus.o_memory_response) extra = 1'b1;
    chk("mid_rst_no_resp", 32'(extra), 32'd0);
    chk("mid_rst_ready", 32'(bus.o_evict_ready), 32'd1);
    chk("mid_rst_overflow", 32'(bus.o_overflow), 32'd0);
    do_fill("mid_rst_read", 32'h0000_0040, L, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Backing-memory responder on the memory side of the 4-way set-associative cache `sa_cache`. It services fill requests raised by the cache's `cache_miss` and returns one 32-bit line word with a single-cycle response pulse. It absorbs eviction writebacks (`o_evict`/`o_evict_addr`/`o_evict_data`) into a small writeback buffer and commits them to a word-addressed storage array. The cache testbench and later system tops instantiate it in place of an ad-hoc memory model.

## Interface
- `ADDR_W`, 32, address width ({tag 18, index 8, offset 6})
- `DATA_W`, 32, line/word width
- `DEPTH_LOG2`, 10, log2 of storage words
- `LATENCY`, 4, fill latency in cycles, ≥1
- `WB_DEPTH`, 4, writeback buffer entries, power of 2
- `clk`  in  1  clock; everything on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `i_miss`  in  1  fill request level, held by cache until served
- `i_miss_addr`  in  ADDR_W  fill address
- `i_evict`  in  1  writeback valid, one cycle per entry
- `i_evict_addr`  in  ADDR_W  writeback address
- `i_evict_data`  in  DATA_W  writeback data
- `o_memory_line`  out  DATA_W  fill data, valid with response
- `o_memory_response`  out  1  one-cycle fill-complete pulse
- `o_evict_ready`  out  1  buffer can accept (count < WB_DEPTH)
- `o_overflow`  out  1  sticky: writeback dropped
- `o_busy`  out  1  FSM not in IDLE

## Operation
- Word index = addr[DEPTH_LOG2+1:2]. Bits [1:0] and upper bits are ignored; upper bits alias.
- Storage array is single-port and not reset.
- Writes happen only in IDLE/DRAIN: one buffer entry (oldest first) per cycle.
- The read occurs on entry to RESP.
- Writeback buffer: FIFO, WB_DEPTH entries.
  - Enqueue when `i_evict && o_evict_ready`.
  - `i_evict` while not ready is dropped and sets `o_overflow`, which stays set until reset.
  - Enqueue and dequeue in the same cycle are both performed.
- FSM states and transitions:
  - IDLE → DRAIN if `i_miss` and (buffer non-empty or enqueue this cycle).
  - IDLE → WAIT if `i_miss` and the buffer stays empty.
  - `i_miss_addr` is captured on leaving IDLE.
  - DRAIN → WAIT when count==0. Evictions arriving during DRAIN extend it.
  - WAIT: counter loaded with LATENCY-1 on entry. → RESP when the counter reaches 0. No array writes; evictions accumulate.
  - RESP: `o_memory_response`=1 and `o_memory_line`=array[captured index] for exactly one cycle. → COOL.
  - COOL: one cycle, ignores `i_miss` (the cache may still hold it for one cycle). → IDLE.
- Only one fill is outstanding at a time. `i_miss` outside IDLE is ignored.
- `o_memory_line` holds its last value after RESP.
- Reset mid-operation:
  - Pending fill is abandoned; no response pulse.
  - Buffer is flushed; its entries are lost.
  - Overflow is cleared.
  - Array contents are retained.

## Timing
- Reset values:
  - `o_memory_line`=0, `o_memory_response`=0, `o_overflow`=0, `o_busy`=0.
  - `o_evict_ready`=0 while `rst`=1, and 1 in the first cycle after.
- Empty buffer: `i_miss` sampled in IDLE at edge k → `o_memory_response` high during the cycle after edge k+LATENCY.
- N buffered entries at acceptance: response after edge k+N+LATENCY, provided no evictions arrive during DRAIN.
- Back-to-back fills: the next `i_miss` can be accepted at the earliest 2 cycles after the response edge (COOL, then IDLE).
- `o_evict_ready` is combinational from the registered count. It does not account for a same-cycle dequeue.

## Structure
- Shared package `cache_pkg`:
  - Holds ADDR_W, DATA_W, TAG_W=18, INDEX_W=8, OFFSET_W=6.
  - Holds the responder state enum (IDLE, DRAIN, WAIT, RESP, COOL).
  - `sa_cache` reuses the field widths.
- Sub-module `wb_fifo`:
  - Parameterised depth/width FIFO with count, full, empty.
  - Reset synchronous with `rst`.
- Top holds the FSM, latency counter, address capture, storage array and overflow flag.

## Test plan
- Reset for 2 cycles, then release:
  - During reset: all outputs 0.
  - Cycle after release: `o_evict_ready`=1, `o_busy`=0.
- Evict 0x00000040/0xDEADBEEF in IDLE, wait 2 cycles, then raise miss at 0x00000040:
  - Response pulses LATENCY cycles after acceptance.
  - Line = 0xDEADBEEF.
- Same-edge evict 0x00000080/0x12345678 and miss 0x00000080 from IDLE:
  - One DRAIN cycle.
  - Response at k+1+LATENCY, line = 0x12345678.
- Miss accepted, then 5 evictions during WAIT (WB_DEPTH=4):
  - 4 accepted; `o_evict_ready`=0 after the 4th.
  - 5th dropped; `o_overflow`=1 and remains set.
  - After COOL, the 4 entries drain in order (read back each via a miss).
- `i_miss` held high one cycle after the response pulse:
  - No second fill.
  - `o_busy` falls to 0 two cycles after the pulse.
- Assert `rst` during WAIT with 2 entries buffered:
  - No response pulse.
  - After release, count=0 and `o_overflow`=0.
  - Earlier committed data is still readable.
